// File: rtl/scroll_display_driver.sv
// Four-digit multiplexed seven-segment driver showing a 4-character window of a
// 16-entry ROM; the window start is latched once per frame so scrolling never tears.
module scroll_display_driver #(
  parameter int          DWELL_CYCLES = 50000,
  parameter int          BLANK_CYCLES = 1000,
  parameter logic [63:0] MSG_INIT     = 64'h0123456789ABCDEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    frame_addr_q, frame_addr_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  function automatic logic [3:0] mem_rd(input logic [3:0] idx);
    mem_rd = MSG_INIT[63 - 4*int'(idx) -: 4];
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    case (c)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    digit_d      = digit_q;
    state_d      = state_q;
    frame_addr_d = frame_addr_q;
    frame_tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q - 2'd1;
      state_d = BLANK;
      if (digit_q == 2'd0) begin
        frame_addr_d = addr;
        frame_tick_d = 1'b1;
      end
    end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
      state_d = DRIVE;
    end
    // Outputs follow the next state so the segment pattern is settled during blanking.
    an_d  = (state_d == DRIVE) ? ~(4'b0001 << digit_d) : 4'b1111;
    seg_d = seg_decode(mem_rd(frame_addr_d + {2'b00, ~digit_d}));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      digit_q      <= 2'd3;
      state_q      <= BLANK;
      frame_addr_q <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      state_q      <= state_d;
      frame_addr_q <= frame_addr_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scroll_display_driver.sv
// Bench for scroll_display_driver: directed scenarios plus random addr/reset
// traffic checked against a cycle-count based reference model.
module tb_scroll_display_driver;

  localparam int D = 8;
  localparam int B = 2;
  localparam int F = 4 * D;
  localparam logic [63:0] MSG  = 64'h0123456789ABCDEF;
  localparam logic [63:0] MSG2 = 64'hFEDCBA9876543210;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [3:0] addr2 = 4'h0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2, ft, ft2;

  int total = 0;
  int bad = 0;

  scroll_display_driver #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .MSG_INIT(MSG)) dut (
    .clk(clk), .reset(reset), .addr(addr), .an(an), .seg(seg), .dp(dp), .frame_tick(ft));

  scroll_display_driver #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .MSG_INIT(MSG2)) dut2 (
    .clk(clk), .reset(reset), .addr(addr2), .an(an2), .seg(seg2), .dp(dp2), .frame_tick(ft2));

  always #5 clk = ~clk;

  logic [6:0] seg_lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] lit_an   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] lit_0123 [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
  logic [6:0] lit_ef01 [4] = '{7'b0000110, 7'b0001110, 7'b1000000, 7'b1111001};
  logic [6:0] lit_5678 [4] = '{7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  logic [6:0] lit_fedc [4] = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110};

  function automatic logic [3:0] nib(input logic [63:0] m, input int i);
    logic [63:0] sh;
    sh = m >> (60 - 4 * i);
    return sh[3:0];
  endfunction

  // Reference model: k = edges since reset; slot, digit and frame follow from k.
  int         k = 0;
  logic [3:0] fa = 4'h0;
  int         mc, md;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_ft;

  always @(posedge clk) begin
    if (!reset) begin
      k  = 0;
      fa = 4'h0;
    end else begin
      k = k + 1;
      if (k % F == 0) fa = addr;
    end
    if (k == 0) begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      exp_ft  = 1'b0;
    end else begin
      mc      = k % D;
      md      = 3 - ((k / D) % 4);
      exp_an  = (mc < B) ? 4'b1111 : ~(4'b0001 << md);
      exp_seg = seg_lut[nib(MSG, (int'(fa) + 3 - md) % 16)];
      exp_ft  = (k % F == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto_phase(input int ph);
    for (int n = 0; n < 2 * F && (k % F) != ph; n++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    addr  = 4'h0;
    repeat (3) tick();
    total += 6;
    if (an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b want=1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL rst_seg got=%b want=1111111", seg); end
    if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b want=1", dp); end
    if (ft !== 1'b0) begin bad++; $display("FAIL rst_ft got=%b want=0", ft); end
    if (an2 !== 4'b1111) begin bad++; $display("FAIL rst_an2 got=%b want=1111", an2); end
    if (seg2 !== 7'b1111111) begin bad++; $display("FAIL rst_seg2 got=%b want=1111111", seg2); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int c, s;
    addr = 4'h0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      c = i % D;
      s = (i / D) % 4;
      total += 2;
      if (an !== ((c < B) ? 4'b1111 : lit_an[s])) begin
        bad++; $display("FAIL basic_an cyc=%0d got=%b want=%b", i, an, (c < B) ? 4'b1111 : lit_an[s]);
      end
      if (ft !== (i == F)) begin
        bad++; $display("FAIL basic_ft cyc=%0d got=%b want=%b", i, ft, (i == F));
      end
      if (c >= B) begin
        total++;
        if (seg !== lit_0123[s]) begin
          bad++; $display("FAIL basic_seg cyc=%0d got=%b want=%b", i, seg, lit_0123[s]);
        end
      end
    end
    total++;
    if (dp !== 1'b1) begin bad++; $display("FAIL basic_dp got=%b want=1", dp); end
  endtask

  task automatic test_wrap();
    int c, s;
    addr = 4'hE;
    goto_phase(F - 1);
    for (int i = 0; i < F; i++) begin
      tick();
      c = i % D;
      s = i / D;
      if (i == 0) begin
        total++;
        if (ft !== 1'b1) begin bad++; $display("FAIL wrap_ft got=%b want=1", ft); end
      end
      if (c >= B) begin
        total += 2;
        if (an !== lit_an[s]) begin bad++; $display("FAIL wrap_an cyc=%0d got=%b want=%b", i, an, lit_an[s]); end
        if (seg !== lit_ef01[s]) begin bad++; $display("FAIL wrap_seg cyc=%0d got=%b want=%b", i, seg, lit_ef01[s]); end
      end
    end
  endtask

  task automatic test_midframe();
    int p, ticks;
    addr = 4'h0;
    goto_phase(F - 1);
    tick();
    goto_phase(18);
    addr  = 4'h5;
    ticks = 0;
    for (int i = 0; i < 13 + F; i++) begin
      tick();
      if (ft === 1'b1) ticks++;
      p = (19 + i) % F;
      if (p % D >= B) begin
        total++;
        if (i < 13 && seg !== lit_0123[p / D]) begin
          bad++; $display("FAIL mid_old_seg ph=%0d got=%b want=%b", p, seg, lit_0123[p / D]);
        end else if (i >= 13 && seg !== lit_5678[p / D]) begin
          bad++; $display("FAIL mid_new_seg ph=%0d got=%b want=%b", p, seg, lit_5678[p / D]);
        end
      end
    end
    total++;
    if (ticks != 1) begin bad++; $display("FAIL mid_ft_count got=%0d want=1", ticks); end
  endtask

  task automatic test_invariant();
    for (int i = 0; i < 3 * F; i++) begin
      addr = 4'($urandom_range(0, 15));
      tick();
      total += 4;
      if ($countones(~an) > 1) begin bad++; $display("FAIL inv_onehot k=%0d an=%b", k, an); end
      if ((k % D) < B && an !== 4'b1111) begin bad++; $display("FAIL inv_blank k=%0d got=%b want=1111", k, an); end
      if (an !== exp_an) begin bad++; $display("FAIL inv_an k=%0d got=%b want=%b", k, an, exp_an); end
      if (seg !== exp_seg) begin bad++; $display("FAIL inv_seg k=%0d got=%b want=%b", k, seg, exp_seg); end
    end
  endtask

  task automatic test_reset_mid();
    int c, s;
    goto_phase(20);
    total++;
    if (an !== 4'b1101) begin bad++; $display("FAIL rmid_pre_an got=%b want=1101", an); end
    reset = 1'b0;
    tick();
    total += 3;
    if (an !== 4'b1111) begin bad++; $display("FAIL rmid_an got=%b want=1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL rmid_seg got=%b want=1111111", seg); end
    if (ft !== 1'b0) begin bad++; $display("FAIL rmid_ft got=%b want=0", ft); end
    reset = 1'b1;
    addr  = 4'h9;
    for (int i = 1; i <= F; i++) begin
      tick();
      c = i % D;
      s = (i / D) % 4;
      if (c >= B) begin
        total += 2;
        if (an !== lit_an[s]) begin bad++; $display("FAIL rmid_an2 cyc=%0d got=%b want=%b", i, an, lit_an[s]); end
        if (seg !== lit_0123[s]) begin bad++; $display("FAIL rmid_seg2 cyc=%0d got=%b want=%b", i, seg, lit_0123[s]); end
      end
    end
    total++;
    if (ft !== 1'b1) begin bad++; $display("FAIL rmid_ft2 got=%b want=1", ft); end
  endtask

  task automatic test_custom_msg();
    int c, s;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    addr2 = 4'h0;
    for (int i = 1; i < F; i++) begin
      tick();
      c = i % D;
      s = i / D;
      if (c >= B) begin
        total += 2;
        if (an2 !== lit_an[s]) begin bad++; $display("FAIL msg2_an cyc=%0d got=%b want=%b", i, an2, lit_an[s]); end
        if (seg2 !== lit_fedc[s]) begin bad++; $display("FAIL msg2_seg cyc=%0d got=%b want=%b", i, seg2, lit_fedc[s]); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      addr  = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      tick();
      total += 3;
      if (an !== exp_an) begin bad++; $display("FAIL rnd_an k=%0d got=%b want=%b", k, an, exp_an); end
      if (seg !== exp_seg) begin bad++; $display("FAIL rnd_seg k=%0d got=%b want=%b", k, seg, exp_seg); end
      if (ft !== exp_ft) begin bad++; $display("FAIL rnd_ft k=%0d got=%b want=%b", k, ft, exp_ft); end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_midframe();
    test_invariant();
    test_reset_mid();
    test_custom_msg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scroll_display_driver.md
Name: scroll_display_driver

Overview:
- Downstream consumer of the button scroller's 4-bit message pointer `addr`.
- Holds a 16-entry character memory of 4-bit codes.
- Time-multiplexes four active-low seven-segment digits so the display shows a 4-character window starting at `addr`, wrapping mod 16.
- Window start is latched once per refresh frame, so a scroll step never tears a frame.

Parameters:
- DWELL_CYCLES, 50000: clock cycles per digit slot. Must be at least 4.
- BLANK_CYCLES, 1000: leading cycles of each slot with all anodes off (anti-ghosting). Must be at least 1 and less than DWELL_CYCLES.
- MSG_INIT, 64'h0123456789ABCDEF: memory contents; entry i = MSG_INIT[63-4i -: 4], so entry 0 = MSG_INIT[63:60].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- addr  input  4  window start pointer from the scroller.
- an  output  4  digit enables, active-low; an[3] = leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1.
- frame_tick  output  1  one-cycle pulse when a new frame's window is latched.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-low; it is sampled only on the rising edge of `clk`.
- Reset (reset==0 at an edge):
  - outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0
  - internal: cnt=0, digit=3, state=BLANK, frame_addr=0
- Reset mid-operation: same values on that edge, regardless of state. No partial slot completes.
- Internal registers:
  - cnt: slot counter, width ceil(log2(DWELL_CYCLES))
  - digit: 2-bit slot index, sequence 3,2,1,0,3,…
  - state: one of {BLANK, DRIVE}
  - frame_addr: 4-bit latched window start
- Slot counting, every non-reset edge:
  - if cnt==DWELL_CYCLES-1: cnt<=0, digit<=digit-1 (0 wraps to 3), state<=BLANK
  - else: cnt<=cnt+1
- FSM transitions:
  - BLANK -> DRIVE on the edge where cnt==BLANK_CYCLES-1 (and cnt is not wrapping).
  - DRIVE -> BLANK on the slot-wrap edge.
  - No other transitions.
- Frame latch: on the slot-wrap edge where digit goes 0->3:
  - frame_addr<=addr, sampled at that edge
  - frame_tick<=1 for exactly that one cycle; 0 otherwise
  - The first frame after reset uses frame_addr=0.
  - addr changes mid-frame take effect only at the next frame latch.
- Character select: char = mem[(frame_addr + (3-digit)) mod 16], using 4-bit wrap addition. Leftmost digit shows mem[frame_addr]; rightmost shows mem[frame_addr+3].
- Output registers, updated on the same edge as the next-state values, so outputs always match the current state/digit:
  - state BLANK: an=4'b1111; seg=decode(char of the new digit), set up during blanking.
  - state DRIVE: an = all ones except an[digit]=0; seg=decode(char).
- Segment decode (hex, active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Timing:
  - an is 1111 for exactly BLANK_CYCLES cycles at the start of each slot, then one-hot-low for DWELL_CYCLES-BLANK_CYCLES cycles.
  - Frame period = 4*DWELL_CYCLES.
  - At most one an bit is low in any cycle.
- Memory: read-only, initialised from MSG_INIT; no write port.

Test Plan:
- Bench parameters for all scenarios: DWELL_CYCLES=8, BLANK_CYCLES=2.
- Reset hold, then release, addr=0:
  - an=1111 for 2 cycles, then an=0111 with seg=1000000 ('0') for 6 cycles.
  - Following slots: an=1011 seg=1111001 ('1'); an=1101 seg=0100100 ('2'); an=1110 seg=0110000 ('3').
  - Frame period = 32 cycles.
- Wrap-around: addr=4'hE held through a frame latch. Next frame shows E, F, 0, 1 on digits 3..0 (seg 0000110, 0001110, 1000000, 1111001).
- Mid-frame addr change: addr 0->5 during the digit-1 slot.
  - Current frame completes showing 0,1,2,3.
  - frame_tick pulses once at the next latch; the following frame shows 5,6,7,8.
- Blanking and one-hot invariant: over 3 frames, check every cycle that an has at most one 0 bit, and that an=1111 in cycles 0-1 of every slot.
- Reset mid-DRIVE: assert reset (=0) while an=1101.
  - Next edge: an=1111, seg=1111111, frame_tick=0.
  - After release, the sequence restarts from digit 3 with frame_addr=0.
- Custom MSG_INIT=64'hFEDCBA9876543210 with addr=0: digits 3..0 show F, E, d, C.
